bsg_mem_1rw_sync_mask_write_bit_initiator: RTL

Requester-side controller that drives the port of a synchronous 1-port bit-masked-write RAM. It accepts read and masked-write commands over a valid/ready interface and issues at most one memory access per cycle. It captures read data on the cycle after each read, when the RAM presents it, and buffers that data into a valid/yumi response stream, so responses are never lost under backpressure. It sits between a client (cache, CSR file, DMA) and the RAM instance.

---
 rtl/bsg_mem_1rw_sync_mask_write_bit_initiator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_initiator.sv
// Requester-side controller for a synchronous 1-port bit-masked-write RAM with a 3-entry response buffer.
// Optional macro BSG_MEM_INITIATOR_CLEAR_EN: zero every RAM word during INIT after reset.
module bsg_mem_1rw_sync_mask_write_bit_initiator #(
  parameter int unsigned width_p       = 1,
  parameter int unsigned els_p         = 1,
  parameter int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     init_done_o,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  typedef enum logic {INIT, READY} state_e;

  state_e state, state_next;
  logic   inflight_r;
  logic   push, pop;

  logic [width_p-1:0] fifo_mem [3];
  logic [1:0]         rd_ptr, wr_ptr, occ;

`ifdef BSG_MEM_INITIATOR_CLEAR_EN
  logic [addr_width_lp-1:0] clr_addr;
  logic                     clr_last;
  assign clr_last = (clr_addr == addr_width_lp'(els_p - 1));
`endif

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= INIT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
`ifdef BSG_MEM_INITIATOR_CLEAR_EN
      INIT:    if (clr_last) state_next = READY;
`else
      INIT:    state_next = READY;
`endif
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

`ifdef BSG_MEM_INITIATOR_CLEAR_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                        clr_addr <= '0;
    else if (state == INIT && !clr_last) clr_addr <= clr_addr + 1'b1;
  end
`endif

  assign init_done_o = (state == READY);
  // Occupancy plus the read whose data arrives this cycle bounds the buffer.
  assign ready_o = (state == READY) && (({1'b0, occ} + {2'b00, inflight_r}) < 3'd3);

  always_comb begin
    mem_v_o      = v_i & ready_o;
    mem_w_o      = v_i & ready_o & w_i;
    mem_addr_o   = addr_i;
    mem_data_o   = data_i;
    mem_w_mask_o = w_mask_i;
`ifdef BSG_MEM_INITIATOR_CLEAR_EN
    // Gated by reset so the sweep never drives the RAM while reset is held.
    if (state == INIT && !reset_i) begin
      mem_v_o      = 1'b1;
      mem_w_o      = 1'b1;
      mem_addr_o   = clr_addr;
      mem_data_o   = '0;
      mem_w_mask_o = '1;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) inflight_r <= 1'b0;
    else         inflight_r <= v_i & ready_o & ~w_i;
  end

  assign push   = inflight_r;
  assign pop    = yumi_i & v_o;
  assign v_o    = (occ != 2'd0);
  assign data_o = fifo_mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= mem_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
